dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: the pipeline MEM stage (core) and a debug/loader master (dbg).
//  Core has fixed priority; dbg gets a starvation-bounded grant and an optional lock for multi-beat bursts.
//  Drives the data memory's address/data/func3/enable inputs, registers read data and returns it one cycle later.
//  Flags misaligned accesses and produces the core stall.
// PARAMETERS
//  MAX_WAIT   8   dbg wait cycles under core contention before dbg is forced a grant (1..255)
//  CNT_W      8   width of the dbg wait counter; must hold MAX_WAIT
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous, active-high reset
//  coreReq_I      in   1   core access request
//  coreWe_I       in   1   1=store, 0=load
//  coreAddr_I     in   32  byte address
//  coreWrData_I   in   32  store data (LSB-aligned)
//  coreFunc3_I    in   3   RV32I func3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  coreGnt_O      out  1   request accepted this cycle (combinational)
//  coreStall_O    out  1   coreReq_I & ~coreGnt_O
//  coreRspValid_O out  1   response valid (one cycle after grant)
//  coreRdData_O   out  32  load data, valid with coreRspValid_O
//  coreErr_O      out  1   misaligned access, valid with coreRspValid_O
//  dbgReq_I / dbgWe_I / dbgAddr_I / dbgWrData_I / dbgFunc3_I   in  1/1/32/32/3   as core
//  dbgLock_I      in   1   keep ownership after this beat
//  dbgGnt_O / dbgRspValid_O / dbgRdData_O / dbgErr_O   out  1/1/32/1   as core
//  memAddr_O      out  32  to data memory address
//  memWrData_O    out  32  to data memory write data
//  memSel_O       out  3   to data memory func3 select
//  memReadEn_O    out  1   granted load, aligned
//  memWriteEn_O   out  1   granted store, aligned
//  memRdData_I    in   32  combinational read data from memory
// BEHAVIOUR
//  Reset: all *_RspValid_O, *_Err_O = 0; *_RdData_O = 0; state = SHARED; waitCnt = 0.
//   memWriteEn_O/memReadEn_O forced 0 while rst high.
//  FSM states: SHARED, DBG_LOCKED.
//   SHARED grant: core if coreReq_I & ~(dbgReq_I & waitCnt==MAX_WAIT); else dbg if dbgReq_I.
//   DBG_LOCKED: only dbg can be granted; coreGnt_O = 0.
//   SHARED->DBG_LOCKED: dbg granted with dbgLock_I=1.
//   DBG_LOCKED->SHARED: dbg granted with dbgLock_I=0, or dbgReq_I low for a cycle.
//  waitCnt: +1 (saturating at MAX_WAIT) each cycle dbgReq_I=1 and dbg not granted; cleared on dbg grant or when dbgReq_I=0.
//  At most one grant per cycle. Memory port muxed combinationally from the granted master; idle -> enables 0, addr/data/sel 0.
//  Misalign: func3[1:0]=01 with addr[0]=1, or func3[1:0]=10 with addr[1:0]!=0.
//   Granted misaligned access asserts neither mem enable (no write) and returns err=1, rdData=0.
//  Latency: grant in cycle N; RspValid high in N+1 for exactly one cycle for both loads and stores.
//   Load data = memRdData_I sampled at end of N; store rdData = 0.
//  Back-to-back grants every cycle allowed; responses never overlap per master.
//  Requester must hold all request fields stable until its Gnt is seen.
//  Reset mid-burst: lock dropped, pending responses discarded (RspValid=0).
// STRUCTURE
//  Shared package: func3 constants (F3_B/H/W/BU/HU), state enum, misalign function.
//  One natural sub-module: dmem_rsp_reg (per-master response register: valid/err/data), instantiated twice.
// TESTING
//  Core LW addr 0x10 after SW 0xDEADBEEF -> grant same cycle, RspValid next cycle, rdData 0xDEADBEEF, err 0.
//  Core LH addr 0x13 -> err=1, memWriteEn_O/memReadEn_O stay 0, rdData 0.
//  Core req every cycle, dbg req held, MAX_WAIT=8 -> dbg granted on 9th cycle, coreStall_O=1 that cycle.
//  dbg SW x4 with dbgLock_I=1,1,1,0, core requesting -> 4 consecutive dbg grants, core stalled, SHARED after beat 4.
//  Assert rst during DBG_LOCKED with pending response -> RspValid 0, state SHARED, core granted first cycle after release.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: func3 codes, arbiter
// states and the access alignment rule.
package dmem_port_arbiter_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_SHARED     = 1'b0,
    ST_DBG_LOCKED = 1'b1
  } arb_state_e;

  // Only the two low address bits matter: halves need bit 0 clear, words both.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    is_misaligned = ((f3[1:0] == F3_H[1:0]) && addr_lo[0]) ||
                    ((f3[1:0] == F3_W[1:0]) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_rsp_reg.sv
// One-cycle response register for a single master: captures grant, error and
// load data so the response appears the cycle after the grant.
module dmem_rsp_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_gnt,
  input  logic        i_misaligned,
  input  logic        i_load,
  input  logic [31:0] i_mem_data,
  output logic        o_valid,
  output logic        o_err,
  output logic [31:0] o_data
);

  logic        r_valid;
  logic        r_err;
  logic [31:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_gnt;
      r_err   <= i_gnt & i_misaligned;
      // Stores and faulted loads return zero data.
      r_data  <= (i_gnt & i_load & ~i_misaligned) ? i_mem_data : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_err   = r_err;
  assign o_data  = r_data;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the single-port data memory: core has priority, the
// debug master gets a starvation-bounded grant and can lock the port for bursts.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coreReq_I,
  input  logic        coreWe_I,
  input  logic [31:0] coreAddr_I,
  input  logic [31:0] coreWrData_I,
  input  logic [2:0]  coreFunc3_I,
  output logic        coreGnt_O,
  output logic        coreStall_O,
  output logic        coreRspValid_O,
  output logic [31:0] coreRdData_O,
  output logic        coreErr_O,
  input  logic        dbgReq_I,
  input  logic        dbgWe_I,
  input  logic [31:0] dbgAddr_I,
  input  logic [31:0] dbgWrData_I,
  input  logic [2:0]  dbgFunc3_I,
  input  logic        dbgLock_I,
  output logic        dbgGnt_O,
  output logic        dbgRspValid_O,
  output logic [31:0] dbgRdData_O,
  output logic        dbgErr_O,
  output logic [31:0] memAddr_O,
  output logic [31:0] memWrData_O,
  output logic [2:0]  memSel_O,
  output logic        memReadEn_O,
  output logic        memWriteEn_O,
  input  logic [31:0] memRdData_I
);

  arb_state_e       r_state;
  arb_state_e       w_state_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_next;
  logic             w_wait_full;
  logic             w_core_gnt;
  logic             w_dbg_gnt;
  logic             w_core_mis;
  logic             w_dbg_mis;
  logic             w_sel_valid;
  logic             w_sel_we;
  logic             w_sel_mis;

  assign w_wait_full = (r_wait_cnt == CNT_W'(MAX_WAIT));
  assign w_core_mis  = is_misaligned(coreFunc3_I, coreAddr_I[1:0]);
  assign w_dbg_mis   = is_misaligned(dbgFunc3_I, dbgAddr_I[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_SHARED;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_SHARED:     if (w_dbg_gnt && dbgLock_I) w_state_next = ST_DBG_LOCKED;
      ST_DBG_LOCKED: if ((w_dbg_gnt && !dbgLock_I) || !dbgReq_I) w_state_next = ST_SHARED;
    endcase
  end

  // Grant decode; core loses priority only once dbg has waited MAX_WAIT cycles.
  always_comb begin
    w_core_gnt = 1'b0;
    w_dbg_gnt  = 1'b0;
    if (r_state == ST_DBG_LOCKED) begin
      w_dbg_gnt = dbgReq_I;
    end else if (coreReq_I && !(dbgReq_I && w_wait_full)) begin
      w_core_gnt = 1'b1;
    end else begin
      w_dbg_gnt = dbgReq_I;
    end
  end

  always_comb begin
    if (!dbgReq_I || w_dbg_gnt) begin
      w_wait_cnt_next = '0;
    end else if (w_wait_full) begin
      w_wait_cnt_next = r_wait_cnt;
    end else begin
      w_wait_cnt_next = r_wait_cnt + 1'b1;
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_we    = 1'b0;
    w_sel_mis   = 1'b0;
    memAddr_O   = '0;
    memWrData_O = '0;
    memSel_O    = '0;
    if (w_core_gnt) begin
      w_sel_valid = 1'b1;
      w_sel_we    = coreWe_I;
      w_sel_mis   = w_core_mis;
      memAddr_O   = coreAddr_I;
      memWrData_O = coreWrData_I;
      memSel_O    = coreFunc3_I;
    end else if (w_dbg_gnt) begin
      w_sel_valid = 1'b1;
      w_sel_we    = dbgWe_I;
      w_sel_mis   = w_dbg_mis;
      memAddr_O   = dbgAddr_I;
      memWrData_O = dbgWrData_I;
      memSel_O    = dbgFunc3_I;
    end
  end

  assign memReadEn_O  = w_sel_valid & ~w_sel_we & ~w_sel_mis & ~rst;
  assign memWriteEn_O = w_sel_valid &  w_sel_we & ~w_sel_mis & ~rst;

  assign coreGnt_O   = w_core_gnt;
  assign dbgGnt_O    = w_dbg_gnt;
  assign coreStall_O = coreReq_I & ~w_core_gnt;

  dmem_rsp_reg u_core_rsp (
    .clk          (clk),
    .rst          (rst),
    .i_gnt        (w_core_gnt),
    .i_misaligned (w_core_mis),
    .i_load       (~coreWe_I),
    .i_mem_data   (memRdData_I),
    .o_valid      (coreRspValid_O),
    .o_err        (coreErr_O),
    .o_data       (coreRdData_O)
  );

  dmem_rsp_reg u_dbg_rsp (
    .clk          (clk),
    .rst          (rst),
    .i_gnt        (w_dbg_gnt),
    .i_misaligned (w_dbg_mis),
    .i_load       (~dbgWe_I),
    .i_mem_data   (memRdData_I),
    .o_valid      (dbgRspValid_O),
    .o_err        (dbgErr_O),
    .o_data       (dbgRdData_O)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: byte-level memory model, arbitration reference
// checked every cycle, plus directed scenarios with literal expectations.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        coreReq_I, coreWe_I, dbgReq_I, dbgWe_I, dbgLock_I;
  logic [31:0] coreAddr_I, coreWrData_I, dbgAddr_I, dbgWrData_I;
  logic [2:0]  coreFunc3_I, dbgFunc3_I;
  logic        coreGnt_O, coreStall_O, coreRspValid_O, coreErr_O;
  logic        dbgGnt_O, dbgRspValid_O, dbgErr_O;
  logic [31:0] coreRdData_O, dbgRdData_O;
  logic [31:0] memAddr_O, memWrData_O, memRdData_I;
  logic [2:0]  memSel_O;
  logic        memReadEn_O, memWriteEn_O;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.MAX_WAIT(MAXW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .coreReq_I(coreReq_I), .coreWe_I(coreWe_I), .coreAddr_I(coreAddr_I),
    .coreWrData_I(coreWrData_I), .coreFunc3_I(coreFunc3_I),
    .coreGnt_O(coreGnt_O), .coreStall_O(coreStall_O), .coreRspValid_O(coreRspValid_O),
    .coreRdData_O(coreRdData_O), .coreErr_O(coreErr_O),
    .dbgReq_I(dbgReq_I), .dbgWe_I(dbgWe_I), .dbgAddr_I(dbgAddr_I),
    .dbgWrData_I(dbgWrData_I), .dbgFunc3_I(dbgFunc3_I), .dbgLock_I(dbgLock_I),
    .dbgGnt_O(dbgGnt_O), .dbgRspValid_O(dbgRspValid_O), .dbgRdData_O(dbgRdData_O),
    .dbgErr_O(dbgErr_O),
    .memAddr_O(memAddr_O), .memWrData_O(memWrData_O), .memSel_O(memSel_O),
    .memReadEn_O(memReadEn_O), .memWriteEn_O(memWriteEn_O), .memRdData_I(memRdData_I)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Word-organised memory device attached to the DUT.
  logic [31:0] dev_mem [0:63];
  logic [31:0] dev_word, dev_shift;
  always_comb begin
    dev_word  = dev_mem[memAddr_O[7:2]];
    dev_shift = dev_word >> {memAddr_O[1:0], 3'b000};
    case (memSel_O)
      F3_B:    memRdData_I = {{24{dev_shift[7]}}, dev_shift[7:0]};
      F3_H:    memRdData_I = {{16{dev_shift[15]}}, dev_shift[15:0]};
      F3_BU:   memRdData_I = {24'h0, dev_shift[7:0]};
      F3_HU:   memRdData_I = {16'h0, dev_shift[15:0]};
      default: memRdData_I = dev_shift;
    endcase
  end
  always @(posedge clk) begin
    if (memWriteEn_O) begin
      case (memSel_O[1:0])
        2'b00:   dev_mem[memAddr_O[7:2]][8*memAddr_O[1:0] +: 8]  <= memWrData_O[7:0];
        2'b01:   dev_mem[memAddr_O[7:2]][8*memAddr_O[1:0] +: 16] <= memWrData_O[15:0];
        default: dev_mem[memAddr_O[7:2]] <= memWrData_O;
      endcase
    end
  end

  // Reference model: flat byte memory and arbitration bookkeeping.
  logic [7:0] mbytes [0:255];
  bit  m_locked;
  int  m_wait;
  bit  e_cv, e_ce, e_dv, e_de;
  logic [31:0] e_cd, e_dd;

  function automatic bit tb_mis(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'd1) return (a % 2) != 0;
    if (f3[1:0] == 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = mbytes[8'(a + i)];
    case (f3)
      F3_B:    return {{24{v[7]}}, v[7:0]};
      F3_H:    return {{16{v[15]}}, v[15:0]};
      F3_BU:   return {24'h0, v[7:0]};
      F3_HU:   return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int n;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) mbytes[8'(a + i)] = d[8*i +: 8];
  endtask

  bit          eg_c, eg_d, x_mis, x_we;
  logic [31:0] x_addr, x_wd, x_ld;
  logic [2:0]  x_f3;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_core_rspv", coreRspValid_O, 0);
      chk("rst_dbg_rspv", dbgRspValid_O, 0);
      chk("rst_core_data", coreRdData_O, 0);
      chk("rst_dbg_err", dbgErr_O, 0);
      chk("rst_mem_we", memWriteEn_O, 0);
      chk("rst_mem_re", memReadEn_O, 0);
      m_locked = 0; m_wait = 0;
      e_cv = 0; e_ce = 0; e_cd = 0; e_dv = 0; e_de = 0; e_dd = 0;
    end else begin
      chk("core_rspv", coreRspValid_O, e_cv);
      chk("core_err", coreErr_O, e_ce);
      chk("core_rdata", coreRdData_O, e_cd);
      chk("dbg_rspv", dbgRspValid_O, e_dv);
      chk("dbg_err", dbgErr_O, e_de);
      chk("dbg_rdata", dbgRdData_O, e_dd);

      if (m_locked) begin
        eg_c = 0; eg_d = dbgReq_I;
      end else begin
        eg_c = coreReq_I && !(dbgReq_I && m_wait == MAXW);
        eg_d = !eg_c && dbgReq_I;
      end
      chk("core_gnt", coreGnt_O, eg_c);
      chk("dbg_gnt", dbgGnt_O, eg_d);
      chk("core_stall", coreStall_O, coreReq_I && !eg_c);

      x_we = eg_c ? coreWe_I : dbgWe_I;
      x_addr = eg_c ? coreAddr_I : eg_d ? dbgAddr_I : 32'h0;
      x_wd   = eg_c ? coreWrData_I : eg_d ? dbgWrData_I : 32'h0;
      x_f3   = eg_c ? coreFunc3_I : eg_d ? dbgFunc3_I : 3'h0;
      x_mis  = tb_mis(x_f3, x_addr);
      chk("mem_addr", memAddr_O, x_addr);
      chk("mem_wdata", memWrData_O, x_wd);
      chk("mem_sel", memSel_O, x_f3);
      chk("mem_re", memReadEn_O, (eg_c || eg_d) && !x_we && !x_mis);
      chk("mem_we", memWriteEn_O, (eg_c || eg_d) && x_we && !x_mis);

      x_ld = ((eg_c || eg_d) && !x_we && !x_mis) ? mdl_load(x_addr, x_f3) : 32'h0;
      e_cv = eg_c; e_ce = eg_c && x_mis; e_cd = eg_c ? x_ld : 32'h0;
      e_dv = eg_d; e_de = eg_d && x_mis; e_dd = eg_d ? x_ld : 32'h0;
      if ((eg_c || eg_d) && x_we && !x_mis) mdl_store(x_addr, x_wd, x_f3);

      if (eg_d) m_locked = dbgLock_I;
      else if (m_locked && !dbgReq_I) m_locked = 0;
      if (!dbgReq_I || eg_d) m_wait = 0;
      else if (m_wait < MAXW) m_wait++;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } acc_t;

  acc_t core_tab [6];
  acc_t dbg_tab  [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic req, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f3);
    coreReq_I = req; coreWe_I = we; coreAddr_I = a; coreWrData_I = d; coreFunc3_I = f3;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3, input logic lk);
    dbgReq_I = req; dbgWe_I = we; dbgAddr_I = a; dbgWrData_I = d; dbgFunc3_I = f3; dbgLock_I = lk;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, beat, ci, di;
    int gcyc [4];
    bit gc, gd;
    for (int i = 0; i < 64; i++) dev_mem[i] = 32'h0;
    for (int i = 0; i < 256; i++) mbytes[i] = 8'h0;
    core_tab[0] = '{1'b1, 32'h21, 32'h000000A5, F3_B};
    core_tab[1] = '{1'b0, 32'h21, 32'h0, F3_BU};
    core_tab[2] = '{1'b0, 32'h21, 32'h0, F3_B};
    core_tab[3] = '{1'b1, 32'h22, 32'h00001234, F3_H};
    core_tab[4] = '{1'b0, 32'h20, 32'h0, F3_W};
    core_tab[5] = '{1'b1, 32'h26, 32'h55555555, F3_W};
    dbg_tab[0]  = '{1'b0, 32'h44, 32'h0, F3_W};
    dbg_tab[1]  = '{1'b1, 32'h30, 32'hCAFEF00D, F3_W};
    dbg_tab[2]  = '{1'b0, 32'h32, 32'h0, F3_HU};
    dbg_tab[3]  = '{1'b0, 32'h31, 32'h0, F3_H};
    dbg_tab[4]  = '{1'b0, 32'h33, 32'h0, F3_B};
    dbg_tab[5]  = '{1'b0, 32'h30, 32'h0, F3_W};

    rst = 1'b1;
    set_dbg(0, 0, 0, 0, F3_W, 0);
    set_core(1, 1, 32'h10, 32'h11111111, F3_W);
    repeat (2) tick();
    @(negedge clk);
    chk("rst_store_blocked", memWriteEn_O, 0);
    tick();

    // Store then load back through the core.
    rst = 1'b0;
    set_core(1, 1, 32'h10, 32'hDEADBEEF, F3_W);
    @(negedge clk);
    chk("sw_gnt", coreGnt_O, 1);
    chk("sw_we", memWriteEn_O, 1);
    tick();
    set_core(1, 0, 32'h10, 0, F3_W);
    @(negedge clk);
    chk("lw_gnt", coreGnt_O, 1);
    chk("sw_rspv", coreRspValid_O, 1);
    chk("sw_rdata_zero", coreRdData_O, 0);
    tick();
    set_core(1, 0, 32'h13, 0, F3_H);
    @(negedge clk);
    chk("lw_data", coreRdData_O, 32'hDEADBEEF);
    chk("lw_err", coreErr_O, 0);
    chk("lh_mis_re", memReadEn_O, 0);
    chk("lh_mis_we", memWriteEn_O, 0);
    tick();
    set_core(1, 0, 32'h13, 0, F3_B);
    @(negedge clk);
    chk("lh_mis_err", coreErr_O, 1);
    chk("lh_mis_data", coreRdData_O, 0);
    tick();
    set_core(1, 0, 32'h12, 0, F3_HU);
    @(negedge clk);
    chk("lb_data", coreRdData_O, 32'hFFFFFFDE);
    tick();
    set_core(0, 0, 0, 0, F3_W);
    @(negedge clk);
    chk("lhu_data", coreRdData_O, 32'h0000DEAD);
    tick();

    // Starvation bound: dbg must win on the ninth contended cycle.
    set_core(1, 0, 32'h10, 0, F3_W);
    set_dbg(1, 0, 32'h14, 0, F3_W, 0);
    got = 0;
    for (int c = 1; c <= 20 && got == 0; c++) begin
      @(negedge clk);
      if (dbgGnt_O) begin
        got = c;
        chk("starve_stall", coreStall_O, 1);
      end
      tick();
    end
    chk("starve_cycle", got, 9);
    set_dbg(0, 0, 0, 0, F3_W, 0);
    @(negedge clk);
    tick();

    // Locked four-beat dbg burst against a continuously requesting core.
    beat = 0;
    for (int c = 0; c < 40 && beat < 4; c++) begin
      set_dbg(1, 1, 32'h40 + 32'(4 * beat), 32'hA0000000 + 32'(beat), F3_W, beat < 3);
      @(negedge clk);
      if (dbgGnt_O) begin
        gcyc[beat] = c;
        if (beat > 0) chk("lock_core_stall", coreStall_O, 1);
        beat++;
      end
      tick();
    end
    chk("lock_beats", beat, 4);
    chk("lock_consecutive", gcyc[3] - gcyc[0], 3);
    set_dbg(0, 0, 0, 0, F3_W, 0);
    @(negedge clk);
    chk("lock_release_core", coreGnt_O, 1);
    tick();

    // Reset while locked with a response in flight.
    set_core(0, 0, 0, 0, F3_W);
    set_dbg(1, 1, 32'h80, 32'h0BADF00D, F3_W, 1);
    @(negedge clk);
    chk("lock_gnt", dbgGnt_O, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_drop_rspv", dbgRspValid_O, 0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    set_core(1, 0, 32'h80, 0, F3_W);
    set_dbg(1, 0, 32'h44, 0, F3_W, 0);
    @(negedge clk);
    chk("post_rst_core_gnt", coreGnt_O, 1);
    chk("post_rst_dbg_gnt", dbgGnt_O, 0);
    tick();

    // Mixed traffic from both masters; each holds its request until granted.
    ci = 0; di = 0;
    for (int c = 0; c < 200 && (ci < 6 || di < 6); c++) begin
      if (ci < 6) set_core(1, core_tab[ci].we, core_tab[ci].addr, core_tab[ci].data, core_tab[ci].f3);
      else        set_core(0, 0, 0, 0, F3_W);
      if (di < 6) set_dbg(1, dbg_tab[di].we, dbg_tab[di].addr, dbg_tab[di].data, dbg_tab[di].f3, 0);
      else        set_dbg(0, 0, 0, 0, F3_W, 0);
      @(negedge clk);
      gc = coreGnt_O;
      gd = dbgGnt_O;
      tick();
      if (gc) ci++;
      if (gd) di++;
    end
    chk("mix_core_done", ci, 6);
    chk("mix_dbg_done", di, 6);
    set_core(0, 0, 0, 0, F3_W);
    set_dbg(0, 0, 0, 0, F3_W, 0);
    repeat (2) begin
      @(negedge clk);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
